// File: rtl/td4_pkg.sv
// TD4 CPU shared definitions: opcode encodings and the decoded-control bundle.
package td4_pkg;

  localparam logic [3:0] OP_ADD_A    = 4'b0000;
  localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
  localparam logic [3:0] OP_IN_A     = 4'b0010;
  localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
  localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
  localparam logic [3:0] OP_ADD_B    = 4'b0101;
  localparam logic [3:0] OP_IN_B     = 4'b0110;
  localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
  localparam logic [3:0] OP_OUT_B    = 4'b1001;
  localparam logic [3:0] OP_OUT_IM   = 4'b1011;
  localparam logic [3:0] OP_JNC      = 4'b1110;
  localparam logic [3:0] OP_JMP      = 4'b1111;

  typedef enum logic [1:0] {SRC_ZERO, SRC_A, SRC_B, SRC_IN} src_sel_e;
  typedef enum logic [1:0] {DST_NONE, DST_A, DST_B, DST_OUT} dst_sel_e;

  typedef struct packed {
    src_sel_e src_sel;
    dst_sel_e dst_sel;
    logic     jump;
    logic     use_carry;
  } ctrl_t;

endpackage

// File: rtl/td4_if.sv
// Tiny Tapeout user-project pin bundle between the harness (master) and the TD4 core (slave).
interface td4_if;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [3:0] register_a;
  logic [3:0] register_b;

  modport master (
    output ui_in, uio_in,
    input  uo_out, uio_out, uio_oe, register_a, register_b
  );

  modport slave (
    input  ui_in, uio_in,
    output uo_out, uio_out, uio_oe, register_a, register_b
  );
endinterface

// File: rtl/td4_cpu_decoder.sv
// TD4 instruction decoder: opcode plus current carry flag to datapath control.
module td4_decoder
  import td4_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       carry,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '{src_sel: SRC_ZERO, dst_sel: DST_NONE, jump: 1'b0, use_carry: 1'b0};
    case (opcode)
      OP_ADD_A:    begin ctrl.src_sel = SRC_A;  ctrl.dst_sel = DST_A; ctrl.use_carry = 1'b1; end
      OP_ADD_B:    begin ctrl.src_sel = SRC_B;  ctrl.dst_sel = DST_B; ctrl.use_carry = 1'b1; end
      OP_MOV_A_IM: ctrl.dst_sel = DST_A;
      OP_MOV_B_IM: ctrl.dst_sel = DST_B;
      OP_MOV_A_B:  begin ctrl.src_sel = SRC_B;  ctrl.dst_sel = DST_A; end
      OP_MOV_B_A:  begin ctrl.src_sel = SRC_A;  ctrl.dst_sel = DST_B; end
      OP_IN_A:     begin ctrl.src_sel = SRC_IN; ctrl.dst_sel = DST_A; end
      OP_IN_B:     begin ctrl.src_sel = SRC_IN; ctrl.dst_sel = DST_B; end
      OP_OUT_B:    begin ctrl.src_sel = SRC_B;  ctrl.dst_sel = DST_OUT; end
      OP_OUT_IM:   ctrl.dst_sel = DST_OUT;
      // JNC sees the carry from before its own execution
      OP_JNC:      ctrl.jump = ~carry;
      OP_JMP:      ctrl.jump = 1'b1;
      default:     ;
    endcase
  end

endmodule

// File: rtl/td4_cpu.sv
// TD4 4-bit CPU core (registers A, B, OUT, PC, carry). Define INTERNAL_ROM_EN to fetch
// from a built-in 16x8 ROM instead of ui_in.
module td4_cpu
  import td4_pkg::*;
#(
  parameter logic [3:0] RESET_PC = 4'h0
) (
  input logic  clk,
  input logic  rst,
  input logic  ena,
  td4_if.slave bus
);

  logic [3:0] reg_a, reg_b, reg_out, pc;
  logic       carry;
  logic [7:0] instr;
  ctrl_t      ctrl;
  logic [3:0] src_val, add_im;
  logic [4:0] sum;

`ifdef INTERNAL_ROM_EN
  logic [7:0] rom_data;
  logic       unused_pins;

  always_comb begin
    case (pc)
      4'h0:    rom_data = 8'hB3;
      4'h1:    rom_data = 8'h01;
      4'h2:    rom_data = 8'hE1;
      4'h3:    rom_data = 8'hF3;
      default: rom_data = 8'h00;
    endcase
  end

  assign instr       = rom_data;
  assign unused_pins = ^{bus.ui_in, bus.uio_in[7:4]};
`else
  logic unused_pins;

  assign instr       = bus.ui_in;
  assign unused_pins = ^bus.uio_in[7:4];
`endif

  td4_decoder u_decoder (
    .opcode (instr[7:4]),
    .carry  (carry),
    .ctrl   (ctrl)
  );

  // One adder serves every move: Im is added only for ADD and immediate loads.
  always_comb begin
    case (ctrl.src_sel)
      SRC_A:   src_val = reg_a;
      SRC_B:   src_val = reg_b;
      SRC_IN:  src_val = bus.uio_in[3:0];
      default: src_val = '0;
    endcase
    add_im = (ctrl.use_carry || ctrl.src_sel == SRC_ZERO) ? instr[3:0] : '0;
    sum    = {1'b0, src_val} + {1'b0, add_im};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_a   <= '0;
      reg_b   <= '0;
      reg_out <= '0;
      carry   <= 1'b0;
      pc      <= RESET_PC;
    end else if (ena) begin
      carry <= ctrl.use_carry & sum[4];
      case (ctrl.dst_sel)
        DST_A:   reg_a   <= sum[3:0];
        DST_B:   reg_b   <= sum[3:0];
        DST_OUT: reg_out <= sum[3:0];
        default: ;
      endcase
      pc <= ctrl.jump ? instr[3:0] : pc + 4'd1;
    end
  end

  assign bus.uo_out     = {pc, reg_out};
  assign bus.uio_out    = {3'b000, carry, 4'b0000};
  assign bus.uio_oe     = 8'hF0;
  assign bus.register_a = reg_a;
  assign bus.register_b = reg_b;

endmodule

// File: tb/tb_td4_cpu.sv
// Scoreboard bench for td4_cpu: directed program fragments then randomized instructions,
// checked against an opcode-level reference model.
module tb_td4_cpu;

  typedef struct {
    int       idx;
    logic [3:0] a, b, o, pc;
    logic       c;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b0;
  td4_if bus ();

  td4_cpu #(.RESET_PC(4'h0)) dut (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_step = 0;
  bit   stim_done = 0;

  int m_a, m_b, m_o, m_pc, m_c;

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s step %0d: got %h, expected %h", nm, idx, act, req);
    end
  endtask

  function automatic logic [7:0] fetch(input logic [7:0] ui);
`ifdef INTERNAL_ROM_EN
    case (m_pc)
      0: return 8'hB3;
      1: return 8'h01;
      2: return 8'hE1;
      3: return 8'hF3;
      default: return 8'h00;
    endcase
`else
    return ui;
`endif
  endfunction

  task automatic model_exec(input logic [7:0] ui, input logic [7:0] uio);
    logic [7:0] ins;
    int opc, im, inp, s, nc, npc;
    ins = fetch(ui);
    opc = int'(ins[7:4]);
    im  = int'(ins[3:0]);
    inp = int'(uio[3:0]);
    nc  = 0;
    npc = (m_pc + 1) % 16;
    case (opc)
      0:  begin s = m_a + im; m_a = s % 16; nc = (s > 15) ? 1 : 0; end
      5:  begin s = m_b + im; m_b = s % 16; nc = (s > 15) ? 1 : 0; end
      3:  m_a = im;
      7:  m_b = im;
      1:  m_a = m_b;
      4:  m_b = m_a;
      2:  m_a = inp;
      6:  m_b = inp;
      9:  m_o = m_b;
      11: m_o = im;
      14: if (m_c == 0) npc = im;
      15: npc = im;
      default: ;
    endcase
    m_c  = nc;
    m_pc = npc;
  endtask

  task automatic step(input logic r, input logic e, input logic [7:0] ui, input logic [7:0] uio);
    exp_t x;
    @(negedge clk);
    #1;
    rst = r; ena = e; bus.ui_in = ui; bus.uio_in = uio;
    @(posedge clk);
    if (r) begin
      m_a = 0; m_b = 0; m_o = 0; m_c = 0; m_pc = 0;
    end else if (e) begin
      model_exec(ui, uio);
    end
    x.idx = n_step; x.a = 4'(m_a); x.b = 4'(m_b); x.o = 4'(m_o); x.pc = 4'(m_pc); x.c = 1'(m_c);
    q.push_back(x);
    n_step++;
  endtask

  // Monitor: compares registered outputs half a cycle after each edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        x = q.pop_front();
        chk("uo_out",     x.idx, bus.uo_out, {x.pc, x.o});
        chk("uio_out",    x.idx, bus.uio_out, {3'b000, x.c, 4'b0000});
        chk("register_a", x.idx, {4'h0, bus.register_a}, {4'h0, x.a});
        chk("register_b", x.idx, {4'h0, bus.register_b}, {4'h0, x.b});
        chk("uio_oe",     x.idx, bus.uio_oe, 8'hF0);
      end
    end
  end

  initial begin
    bus.ui_in = 8'h00; bus.uio_in = 8'h00;
    m_a = 0; m_b = 0; m_o = 0; m_c = 0; m_pc = 0;

    step(1, 1, 8'($urandom), 8'($urandom));
    step(1, 0, 8'($urandom), 8'($urandom));

    step(0, 1, 8'h3E, 8'h00);
    step(0, 1, 8'h03, 8'h00);
    step(0, 1, 8'h80, 8'h00);

    step(0, 1, 8'h3F, 8'h00);
    step(0, 1, 8'h01, 8'h00);
    step(0, 1, 8'hE8, 8'h00);
    step(0, 1, 8'hE8, 8'h00);

    step(0, 1, 8'h60, 8'h05);
    step(0, 1, 8'h90, 8'h05);
    step(0, 1, 8'hBA, 8'h05);

    for (int i = 0; i < 17; i++) step(0, 1, 8'h80, 8'h00);

    step(0, 0, 8'h37, 8'h00);
    step(0, 0, 8'h37, 8'h00);

    step(0, 1, 8'h75, 8'h00);
    step(1, 1, 8'hF9, 8'h00);
    step(0, 1, 8'h80, 8'h00);

    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0),
           8'($urandom), 8'($urandom));

    stim_done = 1;
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/td4_cpu.md
Name: td4_cpu

Overview:
- 4-bit TD4-class CPU core in a Tiny Tapeout user-project wrapper: registers A, B, OUT, PC and carry flag C; one instruction executes per enabled clock.
- Program ROM is external by default: PC is driven out, and the 8-bit instruction at that address is read back on ui_in in the same cycle.
- Sits at the top of the tile: the harness drives ui_in/uio_in and observes uo_out/uio_out plus debug register taps.

Parameters:
- RESET_PC, 4'h0, value loaded into PC on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ena  input  1  execute enable; 0 holds all state.
- ui_in  input  8  instruction byte for the current PC: [7:4] opcode, [3:0] immediate Im.
- uio_in  input  8  [3:0] IN port; [7:4] ignored.
- uo_out  output  8  [3:0] OUT register, [7:4] PC (external ROM address).
- uio_out  output  8  [7:4] = {3'b000, C}; [3:0] = 0.
- uio_oe  output  8  constant 8'hF0.
- register_a  output  4  debug tap of A.
- register_b  output  4  debug tap of B.

Behaviour:
- Reset: on a rising edge with rst=1, A=B=OUT=0, C=0, PC=RESET_PC. Reset wins over ena and any instruction. Mid-program reset restarts from RESET_PC on the next cycle.
- Execution: on a rising edge with rst=0 and ena=1, one instruction completes. Latency is 1 cycle: results are visible after that edge. With ena=0, all registers hold.
- Combinational paths: uo_out, uio_out and register taps are driven directly from registers; there is no combinational path from inputs to outputs.
- Opcode map (Im = ui_in[3:0]):
  - 0000 ADD A,Im: A = A+Im (mod 16); C = carry out.
  - 0101 ADD B,Im: B = B+Im; C = carry out.
  - 0011 MOV A,Im. 0111 MOV B,Im.
  - 0001 MOV A,B. 0100 MOV B,A.
  - 0010 IN A: A = uio_in[3:0]. 0110 IN B: B = uio_in[3:0].
  - 1001 OUT B: OUT = B. 1011 OUT Im: OUT = Im.
  - 1110 JNC Im: PC = Im if C==0, else PC+1.
  - 1111 JMP Im: PC = Im.
  - Any other opcode: NOP.
- Carry: written every executed cycle. Only ADD can set it; every other instruction, including NOP and JNC, clears C to 0. JNC tests the C value from before its own execution.
- PC: PC+1 wraps 15 to 0. Jumps override the increment.
- Every instruction modifies exactly one data register (or none) besides PC and C.

Optional Feature:
- INTERNAL_ROM_EN defined: a 16x8 internal ROM indexed by PC supplies the instruction; ui_in is ignored. Default contents:
  - 0:0xB3 (OUT 3), 1:0x01 (ADD A,1), 2:0xE1 (JNC 1), 3:0xF3 (JMP 3), rest 0x00.
- INTERNAL_ROM_EN undefined: instruction = ui_in. All ports are identical in both builds.

Decomposition:
- Package td4_pkg holds the opcode localparams (OP_ADD_A, OP_ADD_B, OP_MOV_A_IM, OP_MOV_B_IM, OP_MOV_A_B, OP_MOV_B_A, OP_IN_A, OP_IN_B, OP_OUT_B, OP_OUT_IM, OP_JNC, OP_JMP) and a decoded-control struct typedef: src_sel, dst_sel, jump, use_carry.
- One sub-module, td4_decoder, is natural: opcode plus C in, control struct out. The datapath and registers stay in the top.

Test Plan:
- Reset: assert rst for 2 cycles with arbitrary ui_in -> A=B=OUT=0, PC=0, C=0; uio_oe=8'hF0.
- MOV/ADD carry: 0x3E then 0x03 -> A=E,C=0 then A=1,C=1. Next NOP -> C=0.
- JNC: A=F, ADD A,1 (C=1), then JNC 8 -> PC=next+1. Then JNC 8 with C=0 -> PC=8.
- IN/OUT: uio_in=0x5; IN B (0x60), OUT B (0x90) -> register_b=5, uo_out[3:0]=5. Then OUT 0xA (0xBA) -> uo_out[3:0]=A.
- PC wrap and ena: 16 NOPs -> PC 0..F..0. With ena=0 plus ui_in=0x37 -> A and PC unchanged.
- Reset mid-program: rst during JMP 9 -> PC=0, no jump taken.
